// File: rtl/param_combine_pkg.sv
// Shared types for the parameter-combine pipeline.
// foo_t is the parameter type for the b-operand width. combine_op_e encodes the per-channel operation.
package param_combine_pkg;

    typedef logic [10:0] foo_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_CAT  = 2'd2,
        OP_SWAP = 2'd3
    } combine_op_e;

endpackage

// File: rtl/param_combine_if.sv
// Input beat and output FIFO-head bundle for param_combine_pipe.
// The slave side is the block; the master side is the producer and consumer.
interface param_combine_if
    import param_combine_pkg::*;
#(
    parameter       SIZE_A = 4,
    parameter foo_t SIZE_B = 11'd3,
    parameter int   NCHAN  = 2,
    parameter int   DEPTH  = 4
);
    localparam int SB = int'(SIZE_B);
    localparam int W  = SIZE_A + SB;

    logic                         in_valid;
    logic                         in_ready;
    logic [1:0]                   in_op;
    logic [NCHAN*SIZE_A-1:0]      in_a;
    logic [NCHAN*SB-1:0]          in_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [NCHAN*W-1:0]           out_data;
    logic [1:0]                   out_op;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [15:0]                  xfer_cnt;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_op, count, xfer_cnt
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_op, count, xfer_cnt
    );

endinterface

// File: rtl/param_combine_fifo.sv
// Purpose: DEPTH-entry register FIFO; full/empty derived from the occupancy count.
// Latency: a push at edge N is readable on rd_dat after edge N.
// Backpressure: pushes are ignored while full and pops are ignored while empty.
module param_combine_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wr_dat,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage is cleared on reset so the output bus reads zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/param_combine_pipe.sv
// Purpose: per-channel AND/OR/CAT/SWAP of operand pairs, results queued with the op code.
// Latency: beat accepted at edge N is presented on out_data after edge N (no bypass).
// Backpressure: in_ready = !full; no pass-through when full even if out_ready is high.
module param_combine_pipe
    import param_combine_pkg::*;
#(
    parameter       SIZE_A = 4,
    parameter foo_t SIZE_B = 11'd3,
    parameter int   NCHAN  = 2,
    parameter int   DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    param_combine_if.slave  bus
);
    localparam int SB = int'(SIZE_B);
    localparam int W  = SIZE_A + SB;
    localparam int DW = NCHAN * W;
    localparam int FW = DW + 2;
    localparam int CW = $clog2(DEPTH+1);

    if (SIZE_A < 1) begin : g_chk_size_a
        $error("SIZE_A must be at least 1");
    end
    if (SB < 1) begin : g_chk_size_b
        $error("SIZE_B must be in 1..2047");
    end
    if (NCHAN < 1) begin : g_chk_nchan
        $error("NCHAN must be at least 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    logic [DW-1:0] comb_dat;

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        logic [SIZE_A-1:0] a;
        logic [SB-1:0]     b;
        logic [W-1:0]      res;

        assign a = bus.in_a[i*SIZE_A +: SIZE_A];
        assign b = bus.in_b[i*SB +: SB];

        always_comb begin
            res = '0;
            case (combine_op_e'(bus.in_op))
                OP_AND:  res = {{SB{1'b0}}, a} & {{SIZE_A{1'b0}}, b};
                OP_OR:   res = {{SB{1'b0}}, a} | {{SIZE_A{1'b0}}, b};
                OP_CAT:  res = {a, b};
                OP_SWAP: res = {b, a};
                default: res = '0;
            endcase
        end

        assign comb_dat[i*W +: W] = res;
    end

    logic          accept;
    logic          pop;
    logic [FW-1:0] rd_dat;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   xfer_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    param_combine_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (accept),
        .wr_dat ({bus.in_op, comb_dat}),
        .pop    (pop),
        .rd_dat (rd_dat),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.in_ready  = !fifo_full;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = rd_dat[DW-1:0];
    assign bus.out_op    = rd_dat[FW-1 -: 2];
    assign bus.count     = fifo_count;
    assign bus.xfer_cnt  = xfer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_q <= '0;
        end else if (pop) begin
            xfer_q <= xfer_q + 16'd1;
        end
    end

endmodule
